// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver driven by an oversampling clock.
// After a detected start edge, every bit is sampled once at its middle.
// data_valid and frame_err are one-cycle pulses. busy is high whenever
// the receiver is not idle. All outputs come straight from flops.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic               rx_s;
  logic               rx_d_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2:0]         bit_idx_r;
  logic [7:0]         shift_r;
  logic [7:0]         data_out_r;
  logic               data_valid_r;
  logic               frame_err_r;
  logic               busy_r;

  logic               fall_s;
  logic               half_hit_s;
  logic               full_hit_s;
  logic               cnt_clr_s;
  logic               idx_clr_s;
  logic               shift_en_s;
  logic               valid_s;
  logic               err_s;

  assign rx_s       = sync_r[SYNC_STAGES-1];
  assign fall_s     = rx_d_r & ~rx_s;
  assign half_hit_s = (cnt_r == HALF_LAST);
  assign full_hit_s = (cnt_r == FULL_LAST);

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign frame_err  = frame_err_r;
  assign busy       = busy_r;

  // Synchronizer chain on the asynchronous line, plus its one-cycle-delayed copy.
  // Both reset to the idle level so that a line that idles high produces no edge.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b1}};
      rx_d_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx_in};
      rx_d_r <= rx_s;
    end
  end

  // State register.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. Only a real high-to-low transition starts a frame.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (half_hit_s) begin
          if (!rx_s) begin
            state_next_s = DATA;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (full_hit_s && (bit_idx_r == 3'd7)) begin
          state_next_s = STOP;
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (full_hit_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output and datapath control decoded from the current state and the sample points.
  always_comb begin
    cnt_clr_s  = 1'b0;
    idx_clr_s  = 1'b0;
    shift_en_s = 1'b0;
    valid_s    = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_clr_s = 1'b1;
      end
      START: begin
        if (half_hit_s) begin
          cnt_clr_s = 1'b1;
          idx_clr_s = 1'b1;
        end else begin
          cnt_clr_s = 1'b0;
        end
      end
      DATA: begin
        if (full_hit_s) begin
          cnt_clr_s  = 1'b1;
          shift_en_s = 1'b1;
        end else begin
          cnt_clr_s  = 1'b0;
        end
      end
      STOP: begin
        if (full_hit_s) begin
          cnt_clr_s = 1'b1;
          if (rx_s) begin
            valid_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          cnt_clr_s = 1'b0;
        end
      end
      default: begin
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // Oversample counter, bit index and LSB-first shift register.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      if (cnt_clr_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (idx_clr_s) begin
        bit_idx_r <= 3'd0;
      end else if (shift_en_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end else begin
        bit_idx_r <= bit_idx_r;
      end
      if (shift_en_s) begin
        shift_r <= {rx_s, shift_r[7:1]};
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  // Registered outputs. busy follows the state being entered, so it is in step with state_r.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      data_out_r   <= 8'h00;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      data_valid_r <= valid_s;
      frame_err_r  <= err_s;
      busy_r       <= (state_next_s != IDLE);
      if (valid_s) begin
        data_out_r <= shift_r;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

endmodule
